// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, default frame geometry and
// the baud constants also used by the baud generator.
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      STOP,
      WAIT_HIGH
   } uart_state_e;

   localparam int UART_DATA_BITS  = 8;
   localparam int UART_OVERSAMPLE = 16;

   localparam int UART_CLK_HZ = 50_000_000;
   localparam int UART_BAUD   = 115_200;

   // Whole clk cycles between oversample ticks (truncated, 27 at 50 MHz / 115200 x16).
   function automatic int baud_tick_div(input int clk_hz, input int baud, input int oversample);
      return clk_hz / (baud * oversample);
   endfunction

   localparam int UART_TICK_DIV = baud_tick_div(UART_CLK_HZ, UART_BAUD, UART_OVERSAMPLE);

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for asynchronous inputs; reset value is selectable so
// idle-high lines come out of reset looking idle.
module sync_2ff #(
   parameter int               WIDTH   = 1,
   parameter logic [WIDTH-1:0] RST_VAL = '1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] meta_q;
   logic [WIDTH-1:0] sync_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta_q <= RST_VAL;
         sync_q <= RST_VAL;
      end else begin
         meta_q <= d;
         sync_q <= meta_q;
      end
   end

   assign q = sync_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1-style UART receiver: centre-samples each bit using the oversample tick and
// hands completed bytes to the consumer over a valid/ack handshake.
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   IDLE      | line idle, waiting for a falling edge on rx_s
//   START     | counting to the middle of the start bit to validate it
//   DATA      | sampling payload bits LSB first, one per bit period
//   STOP      | sampling the stop bit, publishing the byte or flagging error
//   WAIT_HIGH | after a framing error, waiting for the line to return high
module uart_rx
   import uart_pkg::*;
#(
   parameter int DATA_BITS  = UART_DATA_BITS,
   parameter int OVERSAMPLE = UART_OVERSAMPLE
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 rxClkEn,
   input  logic                 rx,
   input  logic                 dataAck,
   output logic [DATA_BITS-1:0] data,
   output logic                 dataValid,
   output logic                 frameErr,
   output logic                 overrun,
   output logic                 busy
);

   localparam int TICK_W = $clog2(OVERSAMPLE);
   localparam int BIT_W  = $clog2(DATA_BITS);

   localparam logic [TICK_W-1:0] TICK_MID  = TICK_W'(OVERSAMPLE / 2 - 1);
   localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE - 1);
   localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);

   logic rx_s;

   uart_state_e          state_q,      state_d;
   logic [TICK_W-1:0]    tick_cnt_q,   tick_cnt_d;
   logic [BIT_W-1:0]     bit_cnt_q,    bit_cnt_d;
   logic [DATA_BITS-1:0] shift_q,      shift_d;
   logic [DATA_BITS-1:0] data_q,       data_d;
   logic                 data_valid_q, data_valid_d;
   logic                 frame_err_q,  frame_err_d;
   logic                 overrun_q,    overrun_d;

   sync_2ff #(
      .WIDTH   (1),
      .RST_VAL (1'b1)
   ) u_rx_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (rx),
      .q     (rx_s)
   );

   always_comb begin
      state_d      = state_q;
      tick_cnt_d   = tick_cnt_q;
      bit_cnt_d    = bit_cnt_q;
      shift_d      = shift_q;
      data_d       = data_q;
      frame_err_d  = 1'b0;
      overrun_d    = 1'b0;
      // An ack clears the level; an ack with nothing pending has no effect.
      data_valid_d = data_valid_q & ~dataAck;

      case (state_q)
         IDLE: begin
            tick_cnt_d = '0;
            if (!rx_s) begin
               state_d = START;
            end
         end

         START: begin
            if (rxClkEn) begin
               if (tick_cnt_q == TICK_MID) begin
                  tick_cnt_d = '0;
                  if (!rx_s) begin
                     state_d   = DATA;
                     bit_cnt_d = '0;
                  end else begin
                     state_d = IDLE;
                  end
               end else begin
                  tick_cnt_d = tick_cnt_q + TICK_W'(1);
               end
            end
         end

         DATA: begin
            if (rxClkEn) begin
               if (tick_cnt_q == TICK_LAST) begin
                  tick_cnt_d = '0;
                  shift_d    = {rx_s, shift_q[DATA_BITS-1:1]};
                  if (bit_cnt_q == BIT_LAST) begin
                     state_d = STOP;
                  end else begin
                     bit_cnt_d = bit_cnt_q + BIT_W'(1);
                  end
               end else begin
                  tick_cnt_d = tick_cnt_q + TICK_W'(1);
               end
            end
         end

         STOP: begin
            if (rxClkEn) begin
               if (tick_cnt_q == TICK_LAST) begin
                  tick_cnt_d = '0;
                  if (rx_s) begin
                     data_d       = shift_q;
                     data_valid_d = 1'b1;
                     overrun_d    = data_valid_q & ~dataAck;
                     state_d      = IDLE;
                  end else begin
                     frame_err_d = 1'b1;
                     state_d     = WAIT_HIGH;
                  end
               end else begin
                  tick_cnt_d = tick_cnt_q + TICK_W'(1);
               end
            end
         end

         WAIT_HIGH: begin
            tick_cnt_d = '0;
            if (rx_s) begin
               state_d = IDLE;
            end
         end

         default: begin
            state_d    = IDLE;
            tick_cnt_d = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         tick_cnt_q   <= '0;
         bit_cnt_q    <= '0;
         shift_q      <= '0;
         data_q       <= '0;
         data_valid_q <= 1'b0;
         frame_err_q  <= 1'b0;
         overrun_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         tick_cnt_q   <= tick_cnt_d;
         bit_cnt_q    <= bit_cnt_d;
         shift_q      <= shift_d;
         data_q       <= data_d;
         data_valid_q <= data_valid_d;
         frame_err_q  <= frame_err_d;
         overrun_q    <= overrun_d;
      end
   end

   assign data      = data_q;
   assign dataValid = data_valid_q;
   assign frameErr  = frame_err_q;
   assign overrun   = overrun_q;
   assign busy      = (state_q != IDLE);

endmodule
